rgb_pwm_arbiter: RTL and testbench
==================================

# rgb_pwm_arbiter

Shares the board's single tri-colour LED between several requesters and turns each granted 24-bit colour into three 8-bit PWM streams. The streams drive the PWM inputs of the iCE40 hard LED driver, and `led_en` drives its enable. Arbitration and colour changes take effect only at PWM frame boundaries, so the LED never shows a torn colour. Every requester is sequenced through this block.

## Interface
- `NREQ`, default 3: number of requesters. Index 0 has the highest priority.
- `PWM_BITS`, default 8: width of each colour channel and of the PWM counter.
- `PRESCALE`, default 188: system clocks per PWM step. At 48 MHz this gives about 1 kHz frames.
- `HOLD_FRAMES`, default 16: minimum number of frames an owner keeps the LED before a lower-priority requester can take it.
- `clk` in 1: system clock, 48 MHz.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: requester n wants the LED.
- `req_color` in NREQ*3*PWM_BITS: colour for requester n, packed {R,G,B}. Requester n occupies slice n.
- `grant` out NREQ: one-hot current owner, or all zero when no one owns the LED.
- `pwm_r`, `pwm_g`, `pwm_b` out 1: registered PWM to the driver's red, green and blue inputs.
- `led_en` out 1: LED driver enable. It is 1 whenever an owner exists.
- `frame_strobe` out 1: one-cycle pulse on the first clock of each frame.

## Operation
- **Timebase**
  - The prescaler counts 0..PRESCALE-1 and emits `tick` when it reaches PRESCALE-1.
  - On each `tick`, `pwm_cnt` (PWM_BITS wide) increments and wraps from 2^PWM_BITS-1 to 0.
  - A frame boundary (`fb`) is `tick` with `pwm_cnt` equal to all ones.
- **States**
  - IDLE: no owner, `grant`=0, duty registers 0, `led_en`=0.
  - OWN(k): requester k owns the LED. `grant[k]`=1 and `led_en`=1.
- **Arbitration** is evaluated only at `fb`. Let `w` be the lowest-index asserted `req_valid`.
  - IDLE, no request: stay in IDLE.
  - IDLE, request present: go to OWN(w) and load `hold`=HOLD_FRAMES-1.
  - OWN(k), `req_valid[k]` dropped: go to OWN(w) with the hold reloaded. If no request is present, go to IDLE.
  - OWN(k), w<k: preempt to OWN(w) immediately, whatever the value of `hold`. Reload the hold.
  - OWN(k), w>k, `hold`≠0: stay in OWN(k).
  - OWN(k), w>k, `hold`=0: hand over to OWN(w) only if `req_valid[k]` is 0. An owner that is still requesting is never displaced by a lower priority.
  - Staying in OWN(k): decrement `hold` each frame, saturating at 0.
- **Duty**
  - At `fb`, the duty registers load the new owner's `req_color`, or 0 in IDLE.
  - Mid-frame changes to `req_color` are ignored until the next `fb`.
- **PWM**
  - `pwm_x` = registered (`pwm_cnt` < `duty_x`).
  - duty 0 gives the output constantly 0.
  - duty 2^PWM_BITS-1 gives the output high for all but one step per frame.
- **Simultaneous events**
  - A request that rises and falls between frame boundaries is never seen.
  - A `req_valid` change in the same cycle as `fb` uses the sampled value from that cycle.
- **Reset**
  - The asynchronous assert clears the prescaler, `pwm_cnt`, `hold`, state (to IDLE) and duty, and drives all outputs to 0.
  - On deassert, the first frame starts at `pwm_cnt`=0.
  - A reset during OWN drops the grant immediately.

## Timing
- Reset values: `grant`=0, `pwm_r`/`pwm_g`/`pwm_b`=0, `led_en`=0, `frame_strobe`=0.
- `grant`, `led_en` and the duty registers update on the clock edge at which `fb` is true.
- `frame_strobe` is high in the cycle after `fb` is true, which is the first cycle with `pwm_cnt`=0.
- `pwm_x` lags the `pwm_cnt` comparison by 1 clock. The first PWM output of a new colour appears in the cycle after `frame_strobe`.
- Frame length is PRESCALE * 2^PWM_BITS clocks. Request-to-grant latency is at most one frame plus 1 clock.
- Widths:
  - The prescaler is $clog2(PRESCALE) wide.
  - `hold` is $clog2(HOLD_FRAMES+1) wide.
  - The comparison is unsigned.
  - The parameter requirements are PRESCALE≥1 and HOLD_FRAMES≥1.

## Structure
- Package `rgb_pwm_pkg` holds:
  - the `PWM_BITS` default;
  - the `color_t` struct {r,g,b};
  - localparams for the colour slice offsets;
  - the state enum {IDLE, OWN}.
- One sub-module, `rgb_pwm_timebase`, implements the prescaler, `pwm_cnt`, `tick`, `fb` and `frame_strobe`.
- Arbitration, hold, duty and the comparators stay in the top module.

## Test plan
All tests run with PRESCALE=2, PWM_BITS=8 and HOLD_FRAMES=2, giving a frame of 512 clocks.

- **Reset and idle.** Hold `resetn`=0 for 5 clocks, then release it with no requests. Check that all outputs stay 0 and that `frame_strobe` pulses every 512 clocks.
- **Single requester, mid-frame grant.** Assert `req_valid`=001 with colour {0x80,0x00,0xFF} mid-frame.
  - `grant`=001 and `led_en`=1 at the next `fb`.
  - `pwm_r` is high for 256 clocks per frame.
  - `pwm_g` stays 0.
  - `pwm_b` is high for 510 clocks per frame.
- **Preemption and hand-back.** While requester 2 owns the LED, assert `req_valid[0]`.
  - `grant`=001 at the next `fb`, even though `hold` is nonzero.
  - Drop requester 0 and `grant` returns to 100 at the following `fb`.
- **Hold protection.** Requester 1 owns the LED and requester 2 is also requesting. Drop requester 1 after 1 frame, then check `grant` at the next `fb`:
  - a drop within the hold window must still go to 100, because the owner's drop releases the LED;
  - separately, with requester 1 still requesting, `grant` must stay 010 indefinitely.
- **Colour change and mid-frame reset.**
  - Change `req_color` mid-frame and check the duty stays old until the next `frame_strobe`.
  - Pulse `resetn` low mid-frame and check `grant`, `led_en` and `pwm_*` go 0 asynchronously and `pwm_cnt` restarts at 0.

Source files
------------

// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM arbiter: colour layout,
// channel slice offsets and the arbitration state encoding.
package rgb_pwm_pkg;

  localparam int PWM_BITS_DEF = 8;

  typedef struct packed {
    logic [PWM_BITS_DEF-1:0] r;
    logic [PWM_BITS_DEF-1:0] g;
    logic [PWM_BITS_DEF-1:0] b;
  } color_t;

  // Channel offsets inside one {R,G,B} slice, in units of the channel width
  localparam int R_SLOT = 2;
  localparam int G_SLOT = 1;
  localparam int B_SLOT = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  function automatic color_t unpack_color(input logic [3*PWM_BITS_DEF-1:0] v);
    color_t c;
    c.r = v[R_SLOT*PWM_BITS_DEF +: PWM_BITS_DEF];
    c.g = v[G_SLOT*PWM_BITS_DEF +: PWM_BITS_DEF];
    c.b = v[B_SLOT*PWM_BITS_DEF +: PWM_BITS_DEF];
    return c;
  endfunction

endpackage

// File: rtl/rgb_pwm_timebase.sv
// PWM timebase: prescaler, PWM step counter, frame boundary detection
// and the registered first-cycle-of-frame strobe.
module rgb_pwm_timebase
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESCALE = 188
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                tick,
  output logic                fb,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                frame_strobe
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]       pre_r;
  logic [PWM_BITS-1:0] cnt_r;
  logic                strobe_r;

  assign tick         = (pre_r == PRE_LAST);
  assign fb           = tick && (cnt_r == {PWM_BITS{1'b1}});
  assign pwm_cnt      = cnt_r;
  assign frame_strobe = strobe_r;

  // Prescaler, step counter and strobe registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_r    <= '0;
      cnt_r    <= '0;
      strobe_r <= 1'b0;
    end else begin
      if (tick) begin
        pre_r <= '0;
        cnt_r <= cnt_r + {{(PWM_BITS-1){1'b0}}, 1'b1};
      end else begin
        pre_r <= pre_r + {{(PW-1){1'b0}}, 1'b1};
      end
      strobe_r <= fb;
    end
  end

endmodule

// File: rtl/rgb_pwm_arbiter.sv
// Priority arbiter for the shared tri-colour LED. Ownership and duty
// values change only at frame boundaries so a colour is never torn.
module rgb_pwm_arbiter
  import rgb_pwm_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int PRESCALE    = 188,
  parameter int HOLD_FRAMES = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*3*PWM_BITS-1:0] req_color,
  output logic [NREQ-1:0]            grant,
  output logic                       pwm_r,
  output logic                       pwm_g,
  output logic                       pwm_b,
  output logic                       led_en,
  output logic                       frame_strobe
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int CW = 3 * PWM_BITS;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES - 1);

  logic                tick_s;
  logic                fb_s;
  logic [PWM_BITS-1:0] pwm_cnt_s;

  rgb_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .resetn       (resetn),
    .tick         (tick_s),
    .fb           (fb_s),
    .pwm_cnt      (pwm_cnt_s),
    .frame_strobe (frame_strobe)
  );

  arb_state_t          state_r, state_s;
  logic [IW-1:0]       owner_r, owner_s;
  logic [HW-1:0]       hold_r, hold_s;
  logic [NREQ-1:0]     grant_r, grant_s;
  logic                led_en_r;
  logic [PWM_BITS-1:0] duty_r_r, duty_g_r, duty_b_r;
  logic [PWM_BITS-1:0] duty_r_s, duty_g_s, duty_b_s;
  logic                pwm_r_r, pwm_g_r, pwm_b_r;
  logic [IW-1:0]       win_s;
  logic                any_req_s;
  logic [CW-1:0]       sel_color_s;

  // Lowest-index active request wins
  always_comb begin
    win_s     = '0;
    any_req_s = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_s     = IW'(i);
        any_req_s = 1'b1;
      end else begin
        win_s     = win_s;
      end
    end
  end

  // Next ownership and hold, evaluated only at a frame boundary
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    hold_s  = hold_r;
    if (fb_s) begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_s = ST_OWN;
            owner_s = win_s;
            hold_s  = HOLD_LOAD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_OWN: begin
          if (!req_valid[owner_r]) begin
            // Owner released: hand over to the best remaining requester
            if (any_req_s) begin
              owner_s = win_s;
              hold_s  = HOLD_LOAD;
            end else begin
              state_s = ST_IDLE;
              owner_s = '0;
              hold_s  = '0;
            end
          end else if (win_s < owner_r) begin
            owner_s = win_s;
            hold_s  = HOLD_LOAD;
          end else if (hold_r != '0) begin
            hold_s = hold_r - {{(HW-1){1'b0}}, 1'b1};
          end else begin
            hold_s = '0;
          end
        end
        default: begin
          state_s = ST_IDLE;
          owner_s = '0;
          hold_s  = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Grant vector and duty selection for the next owner
  always_comb begin
    grant_s     = '0;
    sel_color_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ((state_s == ST_OWN) && (owner_s == IW'(i))) begin
        grant_s[i]  = 1'b1;
        sel_color_s = req_color[i*CW +: CW];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
    if (fb_s) begin
      duty_r_s = sel_color_s[R_SLOT*PWM_BITS +: PWM_BITS];
      duty_g_s = sel_color_s[G_SLOT*PWM_BITS +: PWM_BITS];
      duty_b_s = sel_color_s[B_SLOT*PWM_BITS +: PWM_BITS];
    end else begin
      duty_r_s = duty_r_r;
      duty_g_s = duty_g_r;
      duty_b_s = duty_b_r;
    end
  end

  // Arbitration, duty and PWM output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= ST_IDLE;
      owner_r  <= '0;
      hold_r   <= '0;
      grant_r  <= '0;
      led_en_r <= 1'b0;
      duty_r_r <= '0;
      duty_g_r <= '0;
      duty_b_r <= '0;
      pwm_r_r  <= 1'b0;
      pwm_g_r  <= 1'b0;
      pwm_b_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      owner_r  <= owner_s;
      hold_r   <= hold_s;
      grant_r  <= grant_s;
      led_en_r <= (state_s == ST_OWN);
      duty_r_r <= duty_r_s;
      duty_g_r <= duty_g_s;
      duty_b_r <= duty_b_s;
      pwm_r_r  <= (pwm_cnt_s < duty_r_r);
      pwm_g_r  <= (pwm_cnt_s < duty_g_r);
      pwm_b_r  <= (pwm_cnt_s < duty_b_r);
    end
  end

  assign grant  = grant_r;
  assign led_en = led_en_r;
  assign pwm_r  = pwm_r_r;
  assign pwm_g  = pwm_g_r;
  assign pwm_b  = pwm_b_r;

endmodule

// File: tb/tb_rgb_pwm_arbiter.sv
// Directed bench for rgb_pwm_arbiter with PRESCALE=2, HOLD_FRAMES=2
// (512-clock frames); expected values are hand-computed constants.
module tb_rgb_pwm_arbiter;
  import rgb_pwm_pkg::*;

  localparam int NREQ  = 3;
  localparam int PB    = 8;
  localparam int FRAME = 512;

  logic              clk;
  logic              resetn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*24-1:0] req_color;
  logic [NREQ-1:0]   grant;
  logic              pwm_r, pwm_g, pwm_b, led_en, frame_strobe;

  int checks;
  int errors;
  int cyc, hr, hg, hb;

  rgb_pwm_arbiter #(
    .NREQ        (NREQ),
    .PWM_BITS    (PB),
    .PRESCALE    (2),
    .HOLD_FRAMES (2)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_color    (req_color),
    .grant        (grant),
    .pwm_r        (pwm_r),
    .pwm_g        (pwm_g),
    .pwm_b        (pwm_b),
    .led_en       (led_en),
    .frame_strobe (frame_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_color(input int idx, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b);
    color_t c;
    c.r = r;
    c.g = g;
    c.b = b;
    req_color[idx*24 +: 24] = c;
  endtask

  // Step on falling edges until frame_strobe, counting cycles and PWM-high samples
  task automatic wait_strobe(input int limit, output int n, output int cr, output int cg,
                             output int cb);
    n = 0; cr = 0; cg = 0; cb = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      cr += int'(pwm_r);
      cg += int'(pwm_g);
      cb += int'(pwm_b);
      if (frame_strobe) break;
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    resetn    = 1'b0;
    req_valid = 3'b000;
    req_color = '0;

    // Reset and idle
    repeat (5) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_led_en", 32'(led_en), 32'd0);
    chk("rst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
    chk("rst_strobe", 32'(frame_strobe), 32'd0);
    resetn = 1'b1;
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("idle_first_frame_len", 32'(cyc), 32'd512);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_led_en", 32'(led_en), 32'd0);
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("idle_frame_len", 32'(cyc), 32'd512);
    chk("idle_pwm_high", 32'(hr + hg + hb), 32'd0);

    // Single requester granted at the next frame boundary
    repeat (100) @(negedge clk);
    set_color(0, 8'h80, 8'h00, 8'hFF);
    req_valid = 3'b001;
    repeat (20) @(negedge clk);
    chk("midframe_no_grant", 32'(grant), 32'd0);
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("req0_wait_len", 32'(cyc), 32'd392);
    chk("req0_grant", 32'(grant), 32'd1);
    chk("req0_led_en", 32'(led_en), 32'd1);
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("req0_frame_len", 32'(cyc), 32'(FRAME));
    chk("req0_pwm_r", 32'(hr), 32'd256);
    chk("req0_pwm_g", 32'(hg), 32'd0);
    chk("req0_pwm_b", 32'(hb), 32'd510);

    // Owner drops, requester 2 takes over; then preemption by 0 and hand-back
    set_color(2, 8'h10, 8'h20, 8'h30);
    req_valid = 3'b100;
    repeat (50) @(negedge clk);
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("handover_to2", 32'(grant), 32'd4);
    repeat (100) @(negedge clk);
    req_valid = 3'b101;
    repeat (10) @(negedge clk);
    chk("preempt_pending", 32'(grant), 32'd4);
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("preempt_grant0", 32'(grant), 32'd1);
    repeat (100) @(negedge clk);
    req_valid = 3'b100;
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("handback_grant2", 32'(grant), 32'd4);
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("req2_pwm_r", 32'(hr), 32'd32);
    chk("req2_pwm_g", 32'(hg), 32'd64);
    chk("req2_pwm_b", 32'(hb), 32'd96);

    // Hold protection: owner 1 dropping inside its hold window releases the LED
    set_color(1, 8'h40, 8'h40, 8'h40);
    req_valid = 3'b110;
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("hold_grant1", 32'(grant), 32'd2);
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("hold_keep1", 32'(grant), 32'd2);
    chk("hold_pwm_r", 32'(hr), 32'd128);
    req_valid = 3'b100;
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("hold_drop_to2", 32'(grant), 32'd4);
    req_valid = 3'b110;
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("hold_regrant1", 32'(grant), 32'd2);
    for (int f = 0; f < 3; f++) begin
      wait_strobe(1000, cyc, hr, hg, hb);
      chk("hold_owner_stays", 32'(grant), 32'd2);
    end

    // Mid-frame colour change is deferred to the next frame
    repeat (200) @(negedge clk);
    set_color(1, 8'hC0, 8'hC0, 8'hC0);
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("color_tail_len", 32'(cyc), 32'd312);
    chk("color_old_kept", 32'(hr), 32'd0);
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("color_new_r", 32'(hr), 32'd384);
    chk("color_new_b", 32'(hb), 32'd384);

    // Mid-frame reset clears outputs at once and restarts the timebase
    repeat (100) @(negedge clk);
    chk("pre_reset_pwm_r", 32'(pwm_r), 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_led_en", 32'(led_en), 32'd0);
    chk("async_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_strobe(1000, cyc, hr, hg, hb);
    chk("post_reset_frame_len", 32'(cyc), 32'd512);
    chk("post_reset_pwm", 32'(hr + hg + hb), 32'd0);
    chk("post_reset_grant", 32'(grant), 32'd2);
    chk("post_reset_led_en", 32'(led_en), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
